// File: rtl/regfile_param.sv
// Two-read / one-write register file with byte-enable writes, an optional
// hardwired-zero entry 0, optional write-to-read forwarding, and a scrub
// engine that zeroes every entry after reset and on clear_req.
module regfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_req,
  output logic                  busy,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_drop,
  input  logic [ADDR_W-1:0]     rs_addr,
  input  logic [ADDR_W-1:0]     rt_addr,
  output logic [DATA_W-1:0]     rs_out,
  output logic [DATA_W-1:0]     rt_out
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam int unsigned NBYTES   = DATA_W / 8;
  localparam bit          ZeroReg  = (ZERO_REG != 0);
  localparam bit          Bypass   = (BYPASS != 0);
  localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StScrub, StIdle} state_e;

  state_e              state;
  logic [ADDR_W-1:0]   ptr;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                scrub;
  logic                wr_to_zero;
  logic                wr_live;
  logic [DATA_W-1:0]   wr_old;
  logic [DATA_W-1:0]   wr_merged;
  logic [DATA_W-1:0]   rs_next;
  logic [DATA_W-1:0]   rt_next;

  assign scrub = (state == StScrub);

  // Byte merge of the incoming write and next-edge read data for both ports.
  always_comb begin
    wr_old     = mem[wr_addr];
    wr_merged  = wr_old;
    for (int i = 0; i < NBYTES; i++) begin
      if (wr_be[i]) wr_merged[8*i +: 8] = wr_data[8*i +: 8];
    end
    wr_to_zero = ZeroReg && (wr_addr == '0);
    // A write in the clear_req edge is still performed; only scrub blocks it.
    wr_live    = we && !scrub && !wr_to_zero;

    if (scrub) begin
      rs_next = '0;
    end else if (ZeroReg && (rs_addr == '0)) begin
      rs_next = '0;
    end else if (Bypass && wr_live && (wr_addr == rs_addr)) begin
      rs_next = wr_merged;
    end else begin
      rs_next = mem[rs_addr];
    end

    if (scrub) begin
      rt_next = '0;
    end else if (ZeroReg && (rt_addr == '0)) begin
      rt_next = '0;
    end else if (Bypass && wr_live && (wr_addr == rt_addr)) begin
      rt_next = wr_merged;
    end else begin
      rt_next = mem[rt_addr];
    end
  end

  // Storage: scrub clears one entry per edge, otherwise the user write lands.
  always_ff @(posedge clk) begin
    if (scrub) begin
      mem[ptr] <= '0;
    end else if (wr_live) begin
      mem[wr_addr] <= wr_merged;
    end
  end

  // Scrub/idle control plus the registered read and drop outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= StScrub;
      ptr     <= '0;
      busy    <= 1'b1;
      rs_out  <= '0;
      rt_out  <= '0;
      wr_drop <= 1'b0;
    end else begin
      rs_out  <= rs_next;
      rt_out  <= rt_next;
      wr_drop <= we && scrub;
      unique case (state)
        StScrub: begin
          ptr <= ptr + 1'b1;
          if (ptr == LastPtr) begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        end
        StIdle: begin
          if (clear_req) begin
            state <= StScrub;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= StScrub;
          ptr   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboarded random + directed bench for regfile_param. Two instances run
// from the same stimulus: one with zero-reg and bypass on, one with both off.
module tb_regfile_param;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clear_req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [AW-1:0] rs_addr = '0;
  logic [AW-1:0] rt_addr = '0;
  logic [3:0]    wr_be = '0;
  logic [DW-1:0] wr_data = '0;

  logic          busy_a, drop_a, busy_b, drop_b;
  logic [DW-1:0] rs_a, rt_a, rs_b, rt_b;

  always #5 clk = ~clk;

  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy_a), .we(we),
    .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_drop(drop_a),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_out(rs_a), .rt_out(rt_a)
  );

  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy_b), .we(we),
    .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_drop(drop_b),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_out(rs_b), .rt_out(rt_b)
  );

  typedef struct packed {
    logic [DW-1:0] rs_a;
    logic [DW-1:0] rt_a;
    logic [DW-1:0] rs_b;
    logic [DW-1:0] rt_b;
    logic          busy;
    logic          drop;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;
  int pushes = 0;
  int pops = 0;

  // Reference: contents per config (0 = zero-reg+bypass, 1 = neither) and the
  // number of edges left in the current scrub. Contents are invisible while
  // scrubbing, so a scrub is modelled as an instant bulk clear plus countdown.
  logic [DW-1:0] mdl [2][DEPTH];
  int remaining = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [3:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] mread(input int c, input logic [AW-1:0] a);
    bit zr;
    bit byp;
    zr  = (c == 0);
    byp = (c == 0);
    if (zr && a == 0) return '0;
    if (byp && we && a == wr_addr && !(zr && wr_addr == 0))
      return merge(mdl[c][a], wr_data, wr_be);
    return mdl[c][a];
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < 2; c++) for (int i = 0; i < DEPTH; i++) mdl[c][i] = '0;
    remaining = DEPTH;
  endfunction

  // Called positioned at a negedge: drive, predict, push, advance one cycle.
  task automatic cycle(input bit cr, input bit w, input logic [AW-1:0] wa,
                       input logic [3:0] be, input logic [DW-1:0] wd,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    exp_t e;
    clear_req = cr; we = w; wr_addr = wa; wr_be = be; wr_data = wd;
    rs_addr = ra; rt_addr = rb;
    if (remaining > 0) begin
      e.drop = w;
      e.rs_a = '0; e.rt_a = '0; e.rs_b = '0; e.rt_b = '0;
      remaining--;
    end else begin
      e.drop = 1'b0;
      e.rs_a = mread(0, ra); e.rt_a = mread(0, rb);
      e.rs_b = mread(1, ra); e.rt_b = mread(1, rb);
      if (w && wa != 0) mdl[0][wa] = merge(mdl[0][wa], wd, be);
      if (w) mdl[1][wa] = merge(mdl[1][wa], wd, be);
      if (cr) model_clear();
    end
    e.busy = (remaining > 0);
    sb.push_back(e);
    pushes++;
    @(negedge clk);
  endtask

  task automatic idle(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    cycle(1'b0, 1'b0, '0, 4'h0, '0, ra, rb);
  endtask

  task automatic rand_cycle(input int clear_odds);
    cycle(($urandom_range(0, clear_odds - 1) == 0), ($urandom_range(0, 9) < 7),
          AW'($urandom_range(0, 7)), 4'($urandom), $urandom,
          AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, " rs_a"}, rs_a, '0);
    chk({tag, " rt_a"}, rt_a, '0);
    chk({tag, " rs_b"}, rs_b, '0);
    chk({tag, " rt_b"}, rt_b, '0);
    chk({tag, " busy_a"}, DW'(busy_a), DW'(1));
    chk({tag, " busy_b"}, DW'(busy_b), DW'(1));
    chk({tag, " drop_a"}, DW'(drop_a), '0);
    chk({tag, " drop_b"}, DW'(drop_b), '0);
  endtask

  // Asynchronous reset from a negedge position; returns at a negedge, released.
  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 reset_checks(tag);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // Monitor: after each rising edge, compare outputs with the oldest prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        pops++;
        chk("rs_a", rs_a, mon_e.rs_a);
        chk("rt_a", rt_a, mon_e.rt_a);
        chk("rs_b", rs_b, mon_e.rs_b);
        chk("rt_b", rt_b, mon_e.rt_b);
        chk("busy_a", DW'(busy_a), DW'(mon_e.busy));
        chk("busy_b", DW'(busy_b), DW'(mon_e.busy));
        chk("wr_drop_a", DW'(drop_a), DW'(mon_e.drop));
        chk("wr_drop_b", DW'(drop_b), DW'(mon_e.drop));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1 reset_checks("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_clear();

    // Post-reset scrub with random traffic: writes dropped, clear_req ignored.
    for (int i = 0; i < DEPTH; i++) rand_cycle(4);
    // Every entry reads back zero.
    for (int i = 0; i < DEPTH; i++) idle(AW'(i), AW'(DEPTH - 1 - i));

    // Byte-enable merge on entry 5, plus a no-op write with be = 0.
    cycle(1'b0, 1'b1, 6'd5, 4'hF, 32'hDEADBEEF, 6'd0, 6'd0);
    cycle(1'b0, 1'b1, 6'd5, 4'h5, 32'h11223344, 6'd0, 6'd0);
    idle(6'd5, 6'd5);
    cycle(1'b0, 1'b1, 6'd5, 4'h0, 32'h00000000, 6'd5, 6'd1);
    idle(6'd5, 6'd5);

    // Same-edge write and read of entry 9.
    cycle(1'b0, 1'b1, 6'd9, 4'hF, 32'hCAFEF00D, 6'd9, 6'd9);
    idle(6'd9, 6'd9);

    // Write to entry 0.
    cycle(1'b0, 1'b1, 6'd0, 4'hF, 32'hFFFFFFFF, 6'd0, 6'd0);
    idle(6'd0, 6'd0);

    // Clear with a same-edge write to 3, then a dropped write to 7.
    cycle(1'b1, 1'b1, 6'd3, 4'hF, 32'h12345678, 6'd3, 6'd3);
    cycle(1'b0, 1'b1, 6'd7, 4'hF, 32'h87654321, 6'd7, 6'd3);
    for (int i = 0; i < DEPTH - 1; i++) idle(6'd3, 6'd7);
    idle(6'd3, 6'd7);
    idle(6'd5, 6'd9);

    // Random traffic on a narrow address range to force collisions.
    for (int i = 0; i < 600; i++) rand_cycle(128);

    // Reset mid-operation with live outputs.
    while (remaining > 0) idle(6'd0, 6'd0);
    cycle(1'b0, 1'b1, 6'd2, 4'hF, 32'h0A0B0C0D, 6'd2, 6'd2);
    cycle(1'b0, 1'b1, 6'd4, 4'hF, 32'h01020304, 6'd2, 6'd4);
    pulse_reset("reset mid-op");

    // Reset at scrub edge 20, then a full scrub with writes being dropped.
    for (int i = 0; i < 20; i++) idle(6'd2, 6'd4);
    pulse_reset("reset mid-scrub");
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 6'd2, 4'hF, 32'h55AA55AA, 6'd2, 6'd4);
    idle(6'd2, 6'd4);
    for (int i = 0; i < 50; i++) rand_cycle(64);

    @(negedge clk);
    chk("scoreboard drained", DW'(sb.size()), '0);
    chk("pops equal pushes", DW'(pops), DW'(pushes));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
